// File: rtl/day1_pkg.sv
// day1_pkg: default widths, sum type and saturating add shared by the calorie reducer
package day1_pkg;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_SUM_W  = 32;
   typedef logic [DEF_SUM_W-1:0] sum_t;
   function automatic sum_t sat_add(input sum_t a, input sum_t b);
      logic [DEF_SUM_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[DEF_SUM_W] ? '1 : s[DEF_SUM_W-1:0];
   endfunction
endpackage

// File: rtl/day1_topk_insert.sv
// day1_topk_insert: combinational sorted insertion of a candidate into K descending registers
module day1_topk_insert
   import day1_pkg::*;
#(
   parameter int K     = 3,
   parameter int SUM_W = DEF_SUM_W
) (
   input  logic [K-1:0][SUM_W-1:0] regs,
   input  logic [SUM_W-1:0]        cand,
   output logic [K-1:0][SUM_W-1:0] ins
);
   logic [K-1:0] gt;
   for (genvar i = 0; i < K; i++) begin : g_slot
      // strict compare so an equal candidate lands below the existing entry
      assign gt[i] = cand > regs[i];
      if (i == 0) begin : g_head
         assign ins[i] = gt[i] ? cand : regs[i];
      end else begin : g_tail
         assign ins[i] = gt[i] ? (gt[i-1] ? regs[i-1] : cand) : regs[i];
      end
   end
endmodule

// File: rtl/day1_calorie_max.sv
// day1_calorie_max: streaming group-sum max reducer; DAY1_TOP3_EN adds a sorted top-3 and top3_sum
module day1_calorie_max
   import day1_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int SUM_W  = DEF_SUM_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_sep,
   input  logic              in_last,
   output logic [SUM_W-1:0]  max_sum,
   output logic [SUM_W-1:0]  top3_sum,
   output logic              done
);
`ifdef DAY1_TOP3_EN
   localparam int K = 3;
`else
   localparam int K = 1;
`endif
   function automatic logic [SUM_W-1:0] sat(input logic [SUM_W-1:0] a, input logic [SUM_W-1:0] b);
      logic [SUM_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
   endfunction
   logic                    take, close, done_q, done_d;
   logic [SUM_W-1:0]        item, acc_sum, acc_q, acc_d;
   logic [K-1:0][SUM_W-1:0] topk_q, topk_d, topk_ins;
   day1_topk_insert #(.K(K), .SUM_W(SUM_W)) u_ins (
      .regs (topk_q),
      .cand (acc_sum),
      .ins  (topk_ins)
   );
   // a separator contributes nothing, so acc_sum is the closing candidate in every case
   always_comb begin
      take    = in_valid && !done_q;
      close   = take && (in_sep || in_last);
      item    = in_sep ? '0 : SUM_W'(in_data);
      acc_sum = sat(acc_q, item);
      acc_d   = clear ? '0 : !take ? acc_q : close ? '0 : acc_sum;
      topk_d  = clear ? '0 : close ? topk_ins : topk_q;
      done_d  = clear ? 1'b0 : done_q || (take && in_last);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         topk_q <= '0;
         done_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         topk_q <= topk_d;
         done_q <= done_d;
      end
   end
   assign max_sum = topk_q[0];
   assign done    = done_q;
`ifdef DAY1_TOP3_EN
   logic [SUM_W-1:0] top3_q, top3_d;
   always_comb begin
      top3_d = clear ? '0 : close ? sat(sat(topk_ins[0], topk_ins[1]), topk_ins[2]) : top3_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) top3_q <= '0;
      else        top3_q <= top3_d;
   end
   assign top3_sum = top3_q;
`else
   assign top3_sum = '0;
`endif
endmodule

// File: tb/tb_day1_calorie_max.sv
// tb_day1_calorie_max: directed self-checking bench for day1_calorie_max
module tb_day1_calorie_max;
   logic        clk = 1'b0;
   logic        rst_n, clear, in_valid, in_sep, in_last;
   logic [31:0] in_data, max_sum, top3_sum;
   logic        done;
   int          errors = 0;
   int          checks = 0;

   day1_calorie_max dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
      .in_data(in_data), .in_sep(in_sep), .in_last(in_last),
      .max_sum(max_sum), .top3_sum(top3_sum), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] d, input logic s, input logic l);
      in_valid = 1'b1; in_data = d; in_sep = s; in_last = l;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = 32'hDEAD_BEEF; in_sep = 1'b0; in_last = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   task automatic top3_chk(input string tag, input logic [31:0] exp);
`ifdef DAY1_TOP3_EN
      chk(tag, top3_sum, exp);
`else
      chk(tag, top3_sum, 32'd0);
`endif
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_sep = 1'b0; in_last = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_max", max_sum, 32'd0);
      chk("reset_top3", top3_sum, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      // example stream: groups 6000/4000/11000/24000/10000
      send(1000, 0, 0); send(2000, 0, 0); send(3000, 0, 0); send(0, 1, 0);
      chk("ex_live_max1", max_sum, 32'd6000);
      send(4000, 0, 0); send(0, 1, 0);
      send(5000, 0, 0); send(6000, 0, 0); send(0, 1, 0);
      send(7000, 0, 0); send(8000, 0, 0); send(9000, 0, 0); send(0, 1, 0);
      chk("ex_live_max2", max_sum, 32'd24000);
      chk("ex_done_early", {31'd0, done}, 32'd0);
      send(10000, 0, 1);
      chk("ex_max", max_sum, 32'd24000);
      chk("ex_done", {31'd0, done}, 32'd1);
      top3_chk("ex_top3", 32'd45000);
      // tokens after done are ignored
      send(100000, 0, 1);
      chk("post_max", max_sum, 32'd24000);
      chk("post_done", {31'd0, done}, 32'd1);
      top3_chk("post_top3", 32'd45000);
      do_clear();
      chk("clear_max", max_sum, 32'd0);
      chk("clear_done", {31'd0, done}, 32'd0);
      chk("clear_top3", top3_sum, 32'd0);
      // single token, no separators
      send(5, 0, 1);
      chk("single_max", max_sum, 32'd5);
      chk("single_done", {31'd0, done}, 32'd1);
      top3_chk("single_top3", 32'd5);
      do_clear();
      // saturation
      send(32'hFFFF_FFF0, 0, 0); send(32'h20, 0, 1);
      chk("sat_max", max_sum, 32'hFFFF_FFFF);
      top3_chk("sat_top3", 32'hFFFF_FFFF);
      do_clear();
      // empty groups and ties
      send(7, 0, 0); send(0, 1, 0); send(0, 1, 0); send(7, 0, 0); send(0, 1, 0);
      send(3, 0, 1);
      chk("tie_max", max_sum, 32'd7);
      top3_chk("tie_top3", 32'd17);
      do_clear();
      // idle cycles hold state even with garbage on the data lines
      send(40, 0, 0);
      in_data = 32'd999; in_sep = 1'b1; in_last = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_done", {31'd0, done}, 32'd0);
      chk("idle_max", max_sum, 32'd0);
      send(2, 0, 1);
      chk("idle_sum", max_sum, 32'd42);
      do_clear();
      // clear mid-stream, with a same-cycle token that must be dropped
      send(100, 0, 0); send(200, 0, 0);
      clear = 1'b1; in_valid = 1'b1; in_data = 32'd300; in_sep = 1'b0; in_last = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      chk("clrpri_done", {31'd0, done}, 32'd0);
      send(9, 0, 1);
      chk("clrmid_max", max_sum, 32'd9);
      top3_chk("clrmid_top3", 32'd9);
      do_clear();
      // async reset mid-cycle clears outputs immediately
      send(20, 0, 0); send(0, 1, 0); send(30, 0, 1);
      chk("prerst_max", max_sum, 32'd30);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_max", max_sum, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_top3", top3_sum, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(11, 0, 1);
      chk("after_rst_max", max_sum, 32'd11);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
